// File: rtl/rx_link_deframer_if.sv
// Decoded-word input bus and framed payload/status output bus of the receive deframer.
// The slave modport is the deframer side; the master modport is the upstream/downstream side.
interface rx_link_deframer_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 RX_VALID;
  logic [15:0]          RX_DATA;
  logic [1:0]           RX_K_CHAR;
  logic [1:0]           CODE_ERR_N;
  logic [1:0]           RD_ERR;
  logic                 ALIGNED;
  logic [15:0]          OUT_DATA;
  logic                 OUT_VALID;
  logic                 OUT_SOP;
  logic                 OUT_EOP;
  logic                 OUT_ERR;
  logic                 LINK_UP;
  logic [CNT_WIDTH-1:0] PKT_CNT;
  logic [CNT_WIDTH-1:0] ERR_CNT;

  modport slave (
    input  RX_VALID, RX_DATA, RX_K_CHAR, CODE_ERR_N, RD_ERR, ALIGNED,
    output OUT_DATA, OUT_VALID, OUT_SOP, OUT_EOP, OUT_ERR, LINK_UP, PKT_CNT, ERR_CNT
  );

  modport master (
    output RX_VALID, RX_DATA, RX_K_CHAR, CODE_ERR_N, RD_ERR, ALIGNED,
    input  OUT_DATA, OUT_VALID, OUT_SOP, OUT_EOP, OUT_ERR, LINK_UP, PKT_CNT, ERR_CNT
  );
endinterface

// File: rtl/rx_link_deframer.sv
// Receive link-layer deframer: delineates K-char framed packets from the 8b/10b word stream,
// checks the per-packet byte checksum and emits a SOP/EOP-marked payload stream with status counters.
module rx_link_deframer #(
  parameter int MAX_WORDS = 256,
  parameter int CNT_WIDTH = 16
) (
  input  logic            EPCS_RxCLK,
  input  logic            EPCS_RxRSTn,
  rx_link_deframer_if.slave bus
);

  localparam int WCW = $clog2(MAX_WORDS + 1);

  typedef enum logic [1:0] {
    S_UNLOCKED = 2'd0,
    S_IDLE     = 2'd1,
    S_PAYLOAD  = 2'd2,
    S_DISCARD  = 2'd3
  } state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t               state_q, state_d;
  logic [15:0]          hold_q, hold_d;
  logic                 hold_vld_q, hold_vld_d;
  logic                 first_q, first_d;
  logic [7:0]           csum_q, csum_d;
  logic [WCW-1:0]       wcnt_q, wcnt_d;
  logic                 sticky_q, sticky_d;
  logic [15:0]          odata_q, odata_d;
  logic                 ovld_q, ovld_d;
  logic                 osop_q, osop_d;
  logic                 oeop_q, oeop_d;
  logic                 oerr_q, oerr_d;
  logic [CNT_WIDTH-1:0] pkt_q, pkt_d;
  logic [CNT_WIDTH-1:0] errc_q, errc_d;

  logic is_data, is_idle, is_sop, is_eop, corrupt;
  logic emit, emit_eop, emit_err;

  // Word classification; a K=01 word with an unrecognised control byte is treated as BADK.
  always_comb begin
    is_data = (bus.RX_K_CHAR == 2'b00);
    is_idle = (bus.RX_K_CHAR == 2'b01) && (bus.RX_DATA[7:0] == 8'hBC);
    is_sop  = (bus.RX_K_CHAR == 2'b01) && (bus.RX_DATA[7:0] == 8'h1C);
    is_eop  = (bus.RX_K_CHAR == 2'b01) && (bus.RX_DATA[7:0] == 8'hFD);
    corrupt = (~&bus.CODE_ERR_N) | (|bus.RD_ERR);
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    first_d    = first_q;
    csum_d     = csum_q;
    wcnt_d     = wcnt_q;
    sticky_d   = sticky_q;
    pkt_d      = pkt_q;
    errc_d     = errc_q;
    emit       = 1'b0;
    emit_eop   = 1'b0;
    emit_err   = 1'b0;

    if (!bus.ALIGNED) begin
      if (state_q == S_PAYLOAD && hold_vld_q) begin
        emit     = 1'b1;
        emit_eop = 1'b1;
        emit_err = 1'b1;
        errc_d   = sat_inc(errc_q);
      end
      hold_vld_d = 1'b0;
      state_d    = S_UNLOCKED;
    end else begin
      unique case (state_q)
        S_UNLOCKED: state_d = S_IDLE;
        S_IDLE: begin
          if (bus.RX_VALID && is_sop) begin
            state_d  = S_PAYLOAD;
            csum_d   = 8'h00;
            wcnt_d   = '0;
            sticky_d = 1'b0;
            first_d  = 1'b1;
          end
        end
        S_PAYLOAD: begin
          if (bus.RX_VALID) begin
            if (is_data && wcnt_q != WCW'(MAX_WORDS)) begin
              csum_d = csum_q + bus.RX_DATA[7:0] + bus.RX_DATA[15:8];
              wcnt_d = wcnt_q + 1'b1;
              if (hold_vld_q) begin
                emit    = 1'b1;
                first_d = 1'b0;
              end
              hold_d     = bus.RX_DATA;
              hold_vld_d = 1'b1;
              if (corrupt) sticky_d = 1'b1;
            end else if (is_eop) begin
              if (hold_vld_q) begin
                emit     = 1'b1;
                emit_eop = 1'b1;
                emit_err = sticky_q | corrupt | (bus.RX_DATA[15:8] != csum_q);
                if (emit_err) errc_d = sat_inc(errc_q);
                else          pkt_d  = sat_inc(pkt_q);
              end else begin
                errc_d = sat_inc(errc_q);
              end
              hold_vld_d = 1'b0;
              state_d    = S_IDLE;
            end else begin
              // Abort: IDLE, BADK, over-length DATA or an SOP that restarts the packet.
              emit       = hold_vld_q;
              emit_eop   = 1'b1;
              emit_err   = 1'b1;
              errc_d     = sat_inc(errc_q);
              hold_vld_d = 1'b0;
              if (is_sop) begin
                csum_d   = 8'h00;
                wcnt_d   = '0;
                sticky_d = 1'b0;
                first_d  = 1'b1;
              end else if (is_idle) begin
                state_d = S_IDLE;
              end else begin
                state_d = S_DISCARD;
              end
            end
          end
        end
        S_DISCARD: begin
          if (bus.RX_VALID) begin
            if (is_sop) begin
              state_d  = S_PAYLOAD;
              csum_d   = 8'h00;
              wcnt_d   = '0;
              sticky_d = 1'b0;
              first_d  = 1'b1;
            end else if (is_eop || is_idle) begin
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_UNLOCKED;
      endcase
    end

    odata_d = emit ? hold_q : odata_q;
    ovld_d  = emit;
    osop_d  = emit & first_q;
    oeop_d  = emit & emit_eop;
    oerr_d  = emit & emit_err;
  end

  always_ff @(posedge EPCS_RxCLK or negedge EPCS_RxRSTn) begin
    if (!EPCS_RxRSTn) begin
      state_q    <= S_UNLOCKED;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      first_q    <= 1'b0;
      csum_q     <= '0;
      wcnt_q     <= '0;
      sticky_q   <= 1'b0;
      odata_q    <= '0;
      ovld_q     <= 1'b0;
      osop_q     <= 1'b0;
      oeop_q     <= 1'b0;
      oerr_q     <= 1'b0;
      pkt_q      <= '0;
      errc_q     <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      first_q    <= first_d;
      csum_q     <= csum_d;
      wcnt_q     <= wcnt_d;
      sticky_q   <= sticky_d;
      odata_q    <= odata_d;
      ovld_q     <= ovld_d;
      osop_q     <= osop_d;
      oeop_q     <= oeop_d;
      oerr_q     <= oerr_d;
      pkt_q      <= pkt_d;
      errc_q     <= errc_d;
    end
  end

  assign bus.OUT_DATA  = odata_q;
  assign bus.OUT_VALID = ovld_q;
  assign bus.OUT_SOP   = osop_q;
  assign bus.OUT_EOP   = oeop_q;
  assign bus.OUT_ERR   = oerr_q;
  assign bus.LINK_UP   = (state_q != S_UNLOCKED);
  assign bus.PKT_CNT   = pkt_q;
  assign bus.ERR_CNT   = errc_q;

endmodule

// File: tb/tb_rx_link_deframer.sv
// Scoreboard bench for rx_link_deframer: directed packets push expected beats, a negedge monitor pops and compares.
module tb_rx_link_deframer;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [18:0] sb[$];

  rx_link_deframer_if #(.CNT_WIDTH(CW)) bif ();

  rx_link_deframer #(.MAX_WORDS(4), .CNT_WIDTH(CW)) dut (
    .EPCS_RxCLK (clk),
    .EPCS_RxRSTn(rst_n),
    .bus        (bif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every presented beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bif.OUT_VALID) begin
      logic [18:0] act, exp;
      act = {bif.OUT_DATA, bif.OUT_SOP, bif.OUT_EOP, bif.OUT_ERR};
      n_chk++;
      if (sb.size() == 0) begin
        $display("FAIL beat: unexpected {data,sop,eop,err}=%h, none expected", act);
      end else begin
        exp = sb.pop_front();
        if (act === exp) n_pass++;
        else $display("FAIL beat: got {data,sop,eop,err}=%h expected %h", act, exp);
      end
    end
  end

  task automatic push(input logic [15:0] d, input logic s, input logic e, input logic r);
    sb.push_back({d, s, e, r});
  endtask

  task automatic word(input logic [15:0] d, input logic [1:0] k,
                      input logic [1:0] cn = 2'b11, input logic [1:0] rd = 2'b00);
    bif.RX_VALID   = 1'b1;
    bif.RX_DATA    = d;
    bif.RX_K_CHAR  = k;
    bif.CODE_ERR_N = cn;
    bif.RD_ERR     = rd;
    @(posedge clk); #1;
    bif.RX_VALID   = 1'b0;
    bif.CODE_ERR_N = 2'b11;
    bif.RD_ERR     = 2'b00;
  endtask

  // Gap cycle: presents an SOP pattern with RX_VALID low, which must be ignored.
  task automatic gap();
    bif.RX_VALID  = 1'b0;
    bif.RX_DATA   = 16'h001C;
    bif.RX_K_CHAR = 2'b01;
    @(posedge clk); #1;
  endtask

  task automatic sop_w();                    word(16'h001C, 2'b01); endtask
  task automatic idle_w();                   word(16'h00BC, 2'b01); endtask
  task automatic eop_w(input logic [7:0] cs); word({cs, 8'hFD}, 2'b01); endtask
  task automatic dat(input logic [15:0] d);  word(d, 2'b00); endtask

  initial begin
    bif.RX_VALID = 1'b0; bif.RX_DATA = '0; bif.RX_K_CHAR = '0;
    bif.CODE_ERR_N = 2'b11; bif.RD_ERR = '0; bif.ALIGNED = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bif.OUT_VALID), 0);
    chk("rst_data", 32'(bif.OUT_DATA), 0);
    chk("rst_pkt", 32'(bif.PKT_CNT), 0);
    chk("rst_err", 32'(bif.ERR_CNT), 0);
    chk("rst_link", 32'(bif.LINK_UP), 0);
    rst_n = 1'b1;
    gap(); gap();
    chk("unaligned_link", 32'(bif.LINK_UP), 0);
    bif.ALIGNED = 1'b1;
    gap();
    chk("aligned_link", 32'(bif.LINK_UP), 1);

    // Good packet: 12+34+56+78 = 0x114 -> checksum 0x14.
    idle_w(); sop_w(); dat(16'h1234);
    push(16'h1234, 1, 0, 0); dat(16'h5678);
    push(16'h5678, 0, 1, 0); eop_w(8'h14);
    chk("good_pkt", 32'(bif.PKT_CNT), 1);
    chk("good_err", 32'(bif.ERR_CNT), 0);

    // Checksum mismatch.
    sop_w(); dat(16'h1234);
    push(16'h1234, 1, 0, 0); dat(16'h5678);
    push(16'h5678, 0, 1, 1); eop_w(8'h15);
    chk("cs_pkt", 32'(bif.PKT_CNT), 1);
    chk("cs_err", 32'(bif.ERR_CNT), 1);

    // Gaps and single-word packet: AB+CD = 0x178 -> 0x78.
    gap(); sop_w(); gap(); dat(16'hABCD); gap();
    push(16'hABCD, 1, 1, 0); eop_w(8'h78); gap();
    chk("single_pkt", 32'(bif.PKT_CNT), 2);

    // Code error on second data word; checksum itself correct (0x66).
    sop_w(); dat(16'h1111);
    push(16'h1111, 1, 0, 0); word(16'h2222, 2'b00, 2'b10);
    push(16'h2222, 0, 1, 1); eop_w(8'h66);
    chk("cerr_err", 32'(bif.ERR_CNT), 2);
    chk("cerr_pkt", 32'(bif.PKT_CNT), 2);

    // IDLE mid-packet.
    sop_w(); dat(16'h3333);
    push(16'h3333, 1, 1, 1); idle_w();
    chk("idle_abort_err", 32'(bif.ERR_CNT), 3);

    // Zero-length packet dropped.
    sop_w(); eop_w(8'h00);
    chk("zero_len_err", 32'(bif.ERR_CNT), 4);

    // Over-length: 5th word aborts, 6th and the EOP are discarded.
    sop_w(); dat(16'h0101);
    push(16'h0101, 1, 0, 0); dat(16'h0202);
    push(16'h0202, 0, 0, 0); dat(16'h0303);
    push(16'h0303, 0, 0, 0); dat(16'h0404);
    push(16'h0404, 0, 1, 1); dat(16'h0505);
    dat(16'h0606); eop_w(8'h00);
    chk("overlen_err", 32'(bif.ERR_CNT), 5);
    dat(16'h0F0F);
    sop_w(); dat(16'h1234);
    push(16'h1234, 1, 1, 0); eop_w(8'h46);
    chk("after_discard_pkt", 32'(bif.PKT_CNT), 3);

    // SOP mid-packet restarts: 01+02 = 0x03.
    sop_w(); dat(16'h7777);
    push(16'h7777, 1, 1, 1); sop_w(); dat(16'h0102);
    push(16'h0102, 1, 1, 0); eop_w(8'h03);
    chk("restart_err", 32'(bif.ERR_CNT), 6);
    chk("restart_pkt", 32'(bif.PKT_CNT), 4);

    // ALIGNED drop after two data words.
    sop_w(); dat(16'h1010);
    push(16'h1010, 1, 0, 0); dat(16'h2020);
    push(16'h2020, 0, 1, 1); bif.ALIGNED = 1'b0; gap();
    chk("unalign_err", 32'(bif.ERR_CNT), 7);
    chk("unalign_link", 32'(bif.LINK_UP), 0);
    sop_w(); dat(16'h5A5A); dat(16'h5B5B); eop_w(8'hB5);
    chk("unalign_ignore_pkt", 32'(bif.PKT_CNT), 4);
    bif.ALIGNED = 1'b1; gap();
    chk("relock_link", 32'(bif.LINK_UP), 1);
    sop_w(); dat(16'h4242);
    push(16'h4242, 1, 1, 0); eop_w(8'h84);
    chk("relock_pkt", 32'(bif.PKT_CNT), 5);

    // ERR_CNT saturates at all-ones.
    for (int i = 0; i < 10; i++) begin
      sop_w(); eop_w(8'h00);
    end
    chk("err_saturate", 32'(bif.ERR_CNT), 15);

    // Asynchronous reset mid-packet.
    sop_w(); dat(16'h5555);
    push(16'h5555, 1, 0, 0); dat(16'h6666);
    @(negedge clk); #1;
    rst_n = 1'b0; #1;
    chk("arst_valid", 32'(bif.OUT_VALID), 0);
    chk("arst_data", 32'(bif.OUT_DATA), 0);
    chk("arst_pkt", 32'(bif.PKT_CNT), 0);
    chk("arst_err", 32'(bif.ERR_CNT), 0);
    chk("arst_link", 32'(bif.LINK_UP), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    eop_w(8'h00); gap(); gap();
    chk("post_reset_err", 32'(bif.ERR_CNT), 0);

    repeat (3) @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rx_link_deframer.md
Name: rx_link_deframer

Overview:
- Receive-side link-layer stage directly downstream of the PCS 8b/10b decoder. Runs in the recovered receive clock domain.
- Consumes the decoded 16-bit word stream with per-byte K flags and error flags, and delineates packets framed by K-character delimiters.
- Verifies a per-packet byte checksum and emits a SOP/EOP-marked payload stream with an error flag, plus status counters.
- No backpressure; the block runs at line rate.

Parameters:
MAX_WORDS, 256, maximum payload words per packet; the next payload word beyond this aborts the packet.
CNT_WIDTH, 16, width of the saturating status counters.

Ports:
EPCS_RxCLK  in  1  receive clock; all logic on rising edge.
EPCS_RxRSTn  in  1  asynchronous active-low reset.
RX_VALID  in  1  input word qualifier; words with RX_VALID=0 are ignored (no state change).
RX_DATA  in  16  decoded word; byte0=[7:0] is first on the wire, byte1=[15:8].
RX_K_CHAR  in  2  per-byte K flag, bit i for byte i.
CODE_ERR_N  in  2  per-byte code error, active low.
RD_ERR  in  2  per-byte running-disparity error, active high.
ALIGNED  in  1  word alignment achieved.
OUT_DATA  out  16  payload word.
OUT_VALID  out  1  OUT_DATA valid this cycle.
OUT_SOP  out  1  first word of packet; qualified by OUT_VALID.
OUT_EOP  out  1  last word of packet; qualified by OUT_VALID.
OUT_ERR  out  1  packet bad; meaningful only on the EOP beat.
LINK_UP  out  1  high while not in UNLOCKED state.
PKT_CNT  out  CNT_WIDTH  good packets delivered; saturating.
ERR_CNT  out  CNT_WIDTH  bad or dropped packets; saturating.

Behaviour:
- Word classes, evaluated only when RX_VALID=1:
  - IDLE: K=01, byte0=8'hBC (K28.5); byte1 is don't-care.
  - SOP: K=01, byte0=8'h1C (K28.0).
  - EOP: K=01, byte0=8'hFD (K29.7); byte1 = checksum.
  - DATA: K=00.
  - Any other K pattern is BADK.
  - A word is corrupt if any CODE_ERR_N bit is 0 or any RD_ERR bit is 1.
- Reset values: all outputs 0; state UNLOCKED; the hold register is empty.
- States are UNLOCKED, IDLE, PAYLOAD and DISCARD.
  - UNLOCKED -> IDLE: on the first cycle ALIGNED=1.
  - IDLE -> PAYLOAD: on SOP. Clear the checksum, word count and sticky error, and set first=1.
  - IDLE: all other word classes are ignored.
- PAYLOAD, on DATA:
  - Add byte0+byte1 to the 8-bit checksum (mod 256) and increment the word count.
  - If a word is held, emit it; OUT_SOP=first, then clear first. Load the new word into the hold register.
  - A corrupt DATA word sets the sticky error.
- PAYLOAD, on EOP:
  - If a word is held, emit it with OUT_EOP=1 and OUT_ERR = sticky | corrupt | (byte1 != checksum).
  - Increment PKT_CNT if OUT_ERR=0, else ERR_CNT. Go to IDLE.
  - An EOP with zero payload words is dropped with no output; ERR_CNT+1, go to IDLE.
- PAYLOAD abort: on IDLE, BADK, or a DATA word when word count = MAX_WORDS.
  - Emit the held word (if any) with EOP=1 and ERR=1; ERR_CNT+1.
  - For IDLE: go to IDLE. Otherwise: go to DISCARD.
- PAYLOAD, SOP received mid-packet:
  - Terminate the current packet as in the abort case (ERR=1, ERR_CNT+1).
  - Then start a new packet as on IDLE->PAYLOAD, in the same cycle.
- DISCARD: ignore all words until EOP or IDLE, then go to IDLE. An SOP goes directly to PAYLOAD.
- ALIGNED=0 in any state: go to UNLOCKED.
  - If in PAYLOAD with a held word, emit it with EOP=1 and ERR=1, and ERR_CNT+1.
  - The hold register is cleared.
- Latency:
  - Outputs are registered.
  - A payload word sampled at cycle n is emitted at cycle m+1, where m is the cycle the next qualifying DATA/EOP/abort word is sampled.
  - OUT_VALID is a single-cycle pulse per word.
- Single-word packet: SOP, DATA, EOP produces one beat with SOP=1 and EOP=1.
- Counters saturate at all-ones and do not wrap.
- OUT_DATA holds its last value when OUT_VALID=0.
- Asynchronous reset mid-packet discards everything; no partial EOP is emitted.

Test Plan:
- Good packet:
  - Stimulus: ALIGNED=1; IDLE; SOP; DATA 16'h1234; DATA 16'h5678; EOP byte1=8'h14.
  - Required response: two beats {1234, SOP}, {5678, EOP, ERR=0}; PKT_CNT=1; ERR_CNT=0.
- Checksum mismatch:
  - Stimulus: same packet as above, but EOP byte1=8'h15.
  - Required response: EOP beat has ERR=1; ERR_CNT=1; PKT_CNT unchanged.
- RX_VALID gaps and single-word packet:
  - Stimulus: RX_VALID=0 inserted between every word; SOP, DATA 16'hABCD, EOP byte1=8'h78.
  - Required response: one beat with SOP=1, EOP=1, ERR=0.
- Error terminations and zero-length drop:
  - Stimulus (a): CODE_ERR_N=2'b10 on the second DATA word.
  - Stimulus (b): IDLE received mid-packet.
  - Stimulus (c): SOP immediately followed by EOP.
  - Required response: (a) ERR=1 on the EOP beat; (b) held word emitted with EOP=1, ERR=1; (c) no output beat and ERR_CNT increments.
- Over-length packet:
  - Stimulus: MAX_WORDS=4; six DATA words, then EOP.
  - Required response: beats for words 1-4, with the 4th carrying EOP=1, ERR=1; DISCARD entered; EOP returns to IDLE; the next good packet is delivered normally.
- ALIGNED drop and reset mid-packet:
  - Stimulus: ALIGNED falls after 2 DATA words.
  - Required response: held word emitted with EOP=1, ERR=1; LINK_UP=0. Further words are ignored until ALIGNED=1.
  - Stimulus: EPCS_RxRSTn asserted mid-packet.
  - Required response: all outputs and counters return to 0 immediately.
